// File: rtl/mem_resp_arb_buf_if.sv
// Response-side bus of the memory-response arbiter: N ingress channels and one egress.
// slave is the arbiter's view; master is the surrounding memory/network side.
interface mem_resp_arb_buf_if #(
  parameter int p_num_arb  = 3,
  parameter int p_msg_bits = 79
);
  localparam int c_src_bits = $clog2(p_num_arb);

  logic [p_num_arb-1:0]            arb_val;
  logic [p_num_arb-1:0]            arb_rdy;
  logic [p_num_arb*p_msg_bits-1:0] arb_msg;
  logic                            gnt_val;
  logic                            gnt_rdy;
  logic [p_msg_bits-1:0]           gnt_msg;
  logic [c_src_bits-1:0]           gnt_src;

  modport master (
    output arb_val, arb_msg, gnt_rdy,
    input  arb_rdy, gnt_val, gnt_msg, gnt_src
  );

  modport slave (
    input  arb_val, arb_msg, gnt_rdy,
    output arb_rdy, gnt_val, gnt_msg, gnt_src
  );
endinterface

// File: rtl/mem_resp_arb_buf.sv
// N-to-1 memory-response arbiter (round-robin or fixed priority) feeding a small
// registered FIFO; every entry carries the index of the channel it came from.
module mem_resp_arb_buf #(
  parameter int p_num_arb   = 3,
  parameter int p_msg_bits  = 79,
  parameter int p_buf_depth = 2,
  parameter int p_rr_mode   = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_resp_arb_buf_if.slave io_bus
);
  localparam int c_src_bits   = $clog2(p_num_arb);
  localparam int c_sum_bits   = c_src_bits + 1;
  localparam int c_ptr_bits   = $clog2(p_buf_depth);
  localparam int c_cnt_bits   = c_ptr_bits + 1;
  localparam int c_entry_bits = c_src_bits + p_msg_bits;

  typedef logic [c_entry_bits-1:0] entry_t;

  entry_t                r_mem [p_buf_depth];
  logic [c_ptr_bits-1:0] r_head;
  logic [c_ptr_bits-1:0] r_tail;
  logic [c_cnt_bits-1:0] r_count;
  logic [c_src_bits-1:0] r_rr_ptr;

  logic                  w_found;
  logic                  w_full;
  logic                  w_enq;
  logic                  w_deq;
  logic [c_src_bits-1:0] w_win;
  logic [p_msg_bits-1:0] w_win_msg;
  logic [p_num_arb-1:0]  w_rdy;

  // Search starts at the RR pointer and wraps explicitly, so p_num_arb need not be a power of two.
  always_comb begin
    logic [c_sum_bits-1:0] v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = '0;
    for (int k = 0; k < p_num_arb; k++) begin
      if (p_rr_mode != 0) begin
        v_idx = {1'b0, r_rr_ptr} + c_sum_bits'(k);
        if (v_idx >= c_sum_bits'(p_num_arb))
          v_idx = v_idx - c_sum_bits'(p_num_arb);
      end else begin
        v_idx = c_sum_bits'(k);
      end
      if (!w_found && io_bus.arb_val[v_idx[c_src_bits-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_idx[c_src_bits-1:0];
      end
    end
  end

  always_comb begin
    w_win_msg = '0;
    for (int i = 0; i < p_num_arb; i++)
      if (w_win == c_src_bits'(i))
        w_win_msg = io_bus.arb_msg[i*p_msg_bits +: p_msg_bits];
  end

  // Ready depends only on full, never on gnt_rdy, so no egress-to-ingress path exists.
  assign w_full = (r_count == c_cnt_bits'(p_buf_depth));
  assign w_enq  = w_found & ~w_full & ~rst;
  assign w_deq  = (r_count != '0) & io_bus.gnt_rdy;

  always_comb begin
    w_rdy = '0;
    if (w_enq)
      w_rdy[w_win] = 1'b1;
  end

  assign io_bus.arb_rdy = w_rdy;
  assign io_bus.gnt_val = (r_count != '0);
  assign {io_bus.gnt_src, io_bus.gnt_msg} = r_mem[r_head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < p_buf_depth; i++)
        r_mem[i] <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_enq) begin
        r_mem[r_tail] <= {w_win, w_win_msg};
        r_tail        <= r_tail + c_ptr_bits'(1);
      end
      if (w_deq)
        r_head <= r_head + c_ptr_bits'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_cnt_bits'(1);
        2'b01:   r_count <= r_count - c_cnt_bits'(1);
        default: r_count <= r_count;
      endcase
      if ((p_rr_mode != 0) && w_enq)
        r_rr_ptr <= (w_win == c_src_bits'(p_num_arb - 1)) ? '0 : w_win + c_src_bits'(1);
    end
  end

`ifndef SYNTHESIS
  a_rdy_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(io_bus.arb_rdy));
  a_no_enq_full: assert property (@(posedge clk) disable iff (rst) !(w_enq && w_full));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (rst) !(w_deq && (r_count == '0)));
  a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
    (io_bus.gnt_val && !io_bus.gnt_rdy) |=> ($stable(io_bus.gnt_msg) && $stable(io_bus.gnt_src)));
`endif
endmodule

// File: tb/tb_mem_resp_arb_buf.sv
// Bench for mem_resp_arb_buf: a round-robin and a fixed-priority instance share stimulus;
// a queue-level reference model checks both every cycle, alongside hand-written vectors.
module tb_mem_resp_arb_buf;
  localparam int N  = 3;
  localparam int MW = 79;
  localparam int D  = 2;
  localparam int SW = 2;
  localparam int EW = SW + MW;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  t_val;
  logic [N*MW-1:0] t_msg;
  logic          t_grdy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mem_resp_arb_buf_if #(.p_num_arb(N), .p_msg_bits(MW)) if_rr ();
  mem_resp_arb_buf_if #(.p_num_arb(N), .p_msg_bits(MW)) if_fx ();

  assign if_rr.arb_val = t_val;
  assign if_rr.arb_msg = t_msg;
  assign if_rr.gnt_rdy = t_grdy;
  assign if_fx.arb_val = t_val;
  assign if_fx.arb_msg = t_msg;
  assign if_fx.gnt_rdy = t_grdy;

  mem_resp_arb_buf #(.p_num_arb(N), .p_msg_bits(MW), .p_buf_depth(D), .p_rr_mode(1)) u_rr (
    .clk(clk), .rst(rst), .io_bus(if_rr));
  mem_resp_arb_buf #(.p_num_arb(N), .p_msg_bits(MW), .p_buf_depth(D), .p_rr_mode(0)) u_fx (
    .clk(clk), .rst(rst), .io_bus(if_fx));

  // index 0 = fixed-priority instance, 1 = round-robin instance
  logic [N-1:0]  d_rdy  [2];
  logic          d_gval [2];
  logic [EW-1:0] d_head [2];
  assign d_rdy[0]  = if_fx.arb_rdy;
  assign d_rdy[1]  = if_rr.arb_rdy;
  assign d_gval[0] = if_fx.gnt_val;
  assign d_gval[1] = if_rr.gnt_val;
  assign d_head[0] = {if_fx.gnt_src, if_fx.gnt_msg};
  assign d_head[1] = {if_rr.gnt_src, if_rr.gnt_msg};

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of pending entries plus a priority pointer.
  int            m_cnt   [2];
  int            m_ptr   [2];
  bit            m_fresh [2];
  logic [EW-1:0] m_q     [2][D];

  function automatic int pick(input int mode, input logic [N-1:0] val, input int ptr);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (mode != 0) ? (ptr + k) % N : k;
      sh  = val >> idx;
      if (sh[0]) return idx;
    end
    return -1;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m]   = 0;
      m_ptr[m]   = 0;
      m_fresh[m] = 1'b1;
      for (int i = 0; i < D; i++) m_q[m][i] = '0;
    end
  endtask

  always @(posedge rst) model_clear();

  always @(posedge clk) begin
    if (rst) model_clear();
    else begin
      for (int m = 0; m < 2; m++) begin
        int w;
        bit enq, deq;
        logic [N*MW-1:0] sh;
        w   = pick(m, t_val, m_ptr[m]);
        enq = (w >= 0) && (m_cnt[m] < D);
        deq = (m_cnt[m] > 0) && t_grdy;
        if (deq) begin
          for (int i = 0; i < D - 1; i++) m_q[m][i] = m_q[m][i+1];
          m_cnt[m]--;
        end
        if (enq) begin
          sh = t_msg >> (w * MW);
          m_q[m][m_cnt[m]] = {SW'(w), sh[MW-1:0]};
          m_cnt[m]++;
          m_fresh[m] = 1'b0;
          if (m == 1) m_ptr[m] = (w + 1) % N;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int w;
      logic [N-1:0] e;
      string tag;
      tag = (m == 1) ? "model_rr" : "model_fx";
      w = pick(m, t_val, m_ptr[m]);
      e = '0;
      if (!rst && (w >= 0) && (m_cnt[m] < D)) e = N'(1) << w;
      chk({tag, "_arb_rdy"}, EW'(d_rdy[m]), EW'(e));
      chk({tag, "_gnt_val"}, EW'(d_gval[m]), EW'(m_cnt[m] != 0));
      if (m_cnt[m] != 0) chk({tag, "_head"}, d_head[m], m_q[m][0]);
      else if (m_fresh[m]) chk({tag, "_head_after_reset"}, d_head[m], '0);
    end
  end

  typedef struct {
    logic [N-1:0]  val;
    logic          grdy;
    logic [N-1:0]  rdy_rr;
    logic [N-1:0]  rdy_fx;
    logic          gval;
    logic [SW-1:0] src_rr;
    logic [SW-1:0] src_fx;
  } vec_t;

  vec_t tbl [22];

  function automatic logic [EW-1:0] tbl_head(input logic [SW-1:0] src);
    logic [7:0] b;
    b = 8'hA0 + 8'h11 * {6'b0, src};
    return {src, 71'h0, b};
  endfunction

  initial begin
    //             val     grdy  rdy_rr  rdy_fx  gval  src_rr src_fx
    tbl[0]  = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0, 2'd0};
    tbl[1]  = '{3'b111, 1'b1, 3'b010, 3'b001, 1'b1, 2'd0, 2'd0};
    tbl[2]  = '{3'b111, 1'b1, 3'b100, 3'b001, 1'b1, 2'd1, 2'd0};
    tbl[3]  = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b1, 2'd2, 2'd0};
    tbl[4]  = '{3'b111, 1'b1, 3'b010, 3'b001, 1'b1, 2'd0, 2'd0};
    tbl[5]  = '{3'b111, 1'b1, 3'b100, 3'b001, 1'b1, 2'd1, 2'd0};
    tbl[6]  = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b1, 2'd2, 2'd0};
    tbl[7]  = '{3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 2'd0, 2'd0};
    tbl[8]  = '{3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 2'd0};
    tbl[9]  = '{3'b110, 1'b0, 3'b010, 3'b010, 1'b0, 2'd0, 2'd0};
    tbl[10] = '{3'b110, 1'b0, 3'b100, 3'b010, 1'b1, 2'd1, 2'd1};
    tbl[11] = '{3'b110, 1'b0, 3'b000, 3'b000, 1'b1, 2'd1, 2'd1};
    tbl[12] = '{3'b110, 1'b0, 3'b000, 3'b000, 1'b1, 2'd1, 2'd1};
    tbl[13] = '{3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 2'd1, 2'd1};
    tbl[14] = '{3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 2'd2, 2'd1};
    tbl[15] = '{3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 2'd0};
    tbl[16] = '{3'b100, 1'b1, 3'b100, 3'b100, 1'b0, 2'd0, 2'd0};
    tbl[17] = '{3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 2'd2, 2'd2};
    tbl[18] = '{3'b101, 1'b1, 3'b001, 3'b001, 1'b0, 2'd0, 2'd0};
    tbl[19] = '{3'b101, 1'b1, 3'b100, 3'b001, 1'b1, 2'd0, 2'd0};
    tbl[20] = '{3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 2'd2, 2'd0};
    tbl[21] = '{3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 2'd0, 2'd0};

    model_clear();
    rst    = 1'b1;
    t_val  = 3'b111;
    t_grdy = 1'b1;
    t_msg  = {79'hC2, 79'hB1, 79'hA0};

    @(negedge clk);
    chk("rst_rr_arb_rdy", EW'(if_rr.arb_rdy), '0);
    chk("rst_fx_arb_rdy", EW'(if_fx.arb_rdy), '0);

    @(posedge clk); #1;
    rst   = 1'b0;
    t_val = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_rr_gnt_val", i), EW'(if_rr.gnt_val), '0);
      chk($sformatf("idle%0d_rr_arb_rdy", i), EW'(if_rr.arb_rdy), '0);
      chk($sformatf("idle%0d_rr_gnt_msg", i), EW'(if_rr.gnt_msg), '0);
      @(posedge clk); #1;
    end

    // Fresh reset so row 0 is the first cycle after release.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 22; i++) begin
      t_val  = tbl[i].val;
      t_grdy = tbl[i].grdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_rr_arb_rdy", i), EW'(if_rr.arb_rdy), EW'(tbl[i].rdy_rr));
      chk($sformatf("tbl%0d_fx_arb_rdy", i), EW'(if_fx.arb_rdy), EW'(tbl[i].rdy_fx));
      chk($sformatf("tbl%0d_rr_gnt_val", i), EW'(if_rr.gnt_val), EW'(tbl[i].gval));
      chk($sformatf("tbl%0d_fx_gnt_val", i), EW'(if_fx.gnt_val), EW'(tbl[i].gval));
      if (tbl[i].gval) begin
        chk($sformatf("tbl%0d_rr_head", i), d_head[1], tbl_head(tbl[i].src_rr));
        chk($sformatf("tbl%0d_fx_head", i), d_head[0], tbl_head(tbl[i].src_fx));
      end
      @(posedge clk); #1;
    end

    // Fill both buffers, then pull reset between clock edges.
    t_val  = 3'b111;
    t_grdy = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_rr_gnt_val", EW'(if_rr.gnt_val), EW'(1'b1));
    chk("full_fx_gnt_val", EW'(if_fx.gnt_val), EW'(1'b1));
    chk("full_rr_arb_rdy", EW'(if_rr.arb_rdy), '0);
    chk("full_fx_arb_rdy", EW'(if_fx.arb_rdy), '0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_rr_gnt_val", EW'(if_rr.gnt_val), '0);
    chk("async_rst_fx_gnt_val", EW'(if_fx.gnt_val), '0);
    @(posedge clk); #1;
    rst    = 1'b0;
    t_val  = '0;
    t_grdy = 1'b1;
    @(negedge clk);
    chk("post_rst_rr_gnt_val", EW'(if_rr.gnt_val), '0);
    chk("post_rst_rr_head", d_head[1], '0);
    chk("post_rst_fx_head", d_head[0], '0);
    @(posedge clk); #1;
    t_val = 3'b111;
    @(negedge clk);
    chk("post_rst_rr_ptr", EW'(if_rr.arb_rdy), EW'(3'b001));

    for (int c = 0; c < 3000; c++) begin
      logic [N*MW-1:0] acc;
      @(posedge clk); #1;
      acc = '0;
      for (int k = 0; k < N; k++) begin
        logic [95:0] r;
        r   = {$urandom(), $urandom(), $urandom()};
        acc = (acc << MW) | (N*MW)'(r[MW-1:0]);
      end
      t_msg  = acc;
      t_val  = N'($urandom_range(0, 7));
      t_grdy = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mem_resp_arb_buf.md
Name: mem_resp_arb_buf

Overview:
- Parametrised N-to-1 memory-response arbiter with a registered output buffer.
- Sits between the memory-side response ports (one per requester channel) and a single network response egress.
- Selects one valid input per cycle, either round-robin or fixed priority, and enqueues the winner into a small FIFO.
- Every message leaves with the index of the channel it came from.
- The FIFO decouples the egress ready from input selection, so there is no combinational path from gnt_rdy to any arb_rdy.

Parameters:
- p_num_arb, 3: number of input channels, >=2.
- p_msg_bits, 79: message width; 71 plus the opaque field width.
- p_buf_depth, 2: output FIFO entries; a power of two, >=2.
- p_rr_mode, 1: 1 selects round-robin; 0 selects fixed priority (lowest index wins).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- arb_val  in  p_num_arb  per-channel response valid.
- arb_rdy  out  p_num_arb  per-channel ready; at most one bit set.
- arb_msg  in  p_num_arb*p_msg_bits  concatenated messages; channel i occupies [i*p_msg_bits +: p_msg_bits].
- gnt_val  out  1  egress valid.
- gnt_rdy  in  1  egress ready.
- gnt_msg  out  p_msg_bits  egress message (FIFO head).
- gnt_src  out  $clog2(p_num_arb)  source channel of gnt_msg.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FIFO empty; head and tail pointers 0; count 0.
  - RR priority pointer 0.
  - gnt_val=0, gnt_msg=0, gnt_src=0.
  - arb_rdy=0 for as long as rst is high.
- Selection, combinational from arb_val, the pointer and full:
  - RR mode: the winner is the first valid index at or after the pointer, searching upward and wrapping from p_num_arb-1 to 0.
  - Fixed mode: the winner is the lowest valid index; the pointer is ignored.
- Ready and enqueue:
  - arb_rdy[winner]=1 only when some arb_val is set and the FIFO is not full; all other bits are 0.
  - Enqueue happens when arb_val[w] & arb_rdy[w]. At most one enqueue per cycle.
  - The stored entry is {w, arb_msg[w]}.
- Pointer update:
  - RR mode only, and only on enqueue.
  - New pointer = (w+1) mod p_num_arb; wrap is explicit, no power-of-two assumption.
  - No update on cycles without an enqueue, so an idle cycle does not rotate priority.
- Dequeue and egress:
  - Dequeue when gnt_val & gnt_rdy.
  - gnt_val = (count != 0). gnt_msg and gnt_src are driven from the head register, not from inputs.
  - gnt_msg and gnt_src are don't-care when gnt_val=0, but the implementation drives the head entry (0 after reset).
- Latency:
  - An input accepted in cycle t is visible on gnt_val at t+1 if the FIFO was empty.
  - Otherwise it appears in FIFO order.
- Throughput:
  - One message per cycle sustained when gnt_rdy is held high, for any p_buf_depth>=2.
- Simultaneous events:
  - Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
  - When full, arb_rdy is 0 even if a dequeue happens that cycle. This is intentional: it removes the ready path.
- Boundary conditions:
  - Empty: dequeue is impossible because gnt_val=0.
  - Full: no enqueue.
  - Pointers wrap modulo p_buf_depth.
  - Count is $clog2(p_buf_depth)+1 bits wide.
- Stability: an input whose arb_val drops before being accepted is legal. It loses its turn, and no state changes.
- Reset mid-operation: buffered messages are discarded; no partial state survives.
- Assertions (simulation only):
  - onehot0(arb_rdy).
  - No enqueue while full.
  - No dequeue while empty.
  - gnt_msg and gnt_src stable while gnt_val & !gnt_rdy.

Test Plan:
- Reset, then all inputs idle for 5 cycles -> gnt_val=0 and arb_rdy=0 every cycle; gnt_msg=0.
- RR mode, N=3, all arb_val=1 continuously with msgs 0xA0/0xB1/0xC2, gnt_rdy=1 -> egress order src 0,1,2,0,1,2 at one per cycle; first gnt_val one cycle after release of reset.
- Fixed mode, same stimulus -> every output is src 0, msg 0xA0; arb_rdy[1] and arb_rdy[2] never assert.
- Backpressure: gnt_rdy=0 for 4 cycles, inputs 1 and 2 valid -> exactly 2 enqueues, then arb_rdy=0; gnt_msg held at the first message. Releasing gnt_rdy drains in order with no loss or duplication.
- RR wrap and idle: only input 2 valid for one accept, then inputs 0 and 2 valid -> input 0 wins next (pointer wrapped to 0). An idle cycle in between does not change the winner.
- Asynchronous reset asserted mid-cycle with 2 entries buffered -> gnt_val falls immediately without a clock edge. After deassert the FIFO is empty, the pointer is 0, and no stale message appears.
